// File: rtl/regfile_wb_if.sv
// Write-back request bus: NREQ producers each present one register write,
// and the arbiter grants at most one of them per cycle.
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file write port,
// plus a per-register busy scoreboard for issue-stage hazard stalls.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          Reset,
    regfile_wb_if.slave   wb,
    output logic          RegWE,
    output logic [AW-1:0] nD,
    output logic [DW-1:0] D,
    input  logic          mark_valid,
    input  logic [AW-1:0] mark_addr,
    output logic          mark_ready,
    input  logic [AW-1:0] nA,
    input  logic [AW-1:0] nB,
    input  logic [AW-1:0] nC,
    output logic          busyA,
    output logic          busyB,
    output logic          busyC,
    output logic          idle
);
    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int NR = 1 << AW;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx;
    logic            found;
    logic [NREQ-1:0] grant;
    int              idx;
    int              base;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            regwe_q;
    logic [AW-1:0]   nd_q;
    logic [DW-1:0]   d_q;
    logic [NR-1:0]   busy_q, busy_d;

    // Search from ptr upward with wrap-around; nothing is granted during reset.
    always_comb begin
        grant = '0;
        gidx  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && !Reset && wb.req_valid[PW'(idx)]) begin
                found            = 1'b1;
                gidx             = PW'(idx);
                grant[PW'(idx)]  = 1'b1;
            end
        end
    end

    always_comb begin
        base     = int'(gidx);
        sel_addr = wb.req_addr[base*AW +: AW];
        sel_data = wb.req_data[base*DW +: DW];
        ptr_d    = ptr_q;
        if (found) ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end

    assign wb.req_ready = grant;

    // Clear for the write committing at this edge, then set for a new mark,
    // so a simultaneous set/clear of one register leaves it busy.
    assign mark_ready = ~busy_q[mark_addr] & ~Reset;

    always_comb begin
        busy_d = busy_q;
        if (regwe_q) busy_d[nd_q] = 1'b0;
        if (mark_valid && mark_ready) busy_d[mark_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            regwe_q <= 1'b0;
            nd_q    <= '0;
            d_q     <= '0;
            ptr_q   <= '0;
            busy_q  <= '0;
        end else begin
            regwe_q <= found;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            if (found) begin
                nd_q <= sel_addr;
                d_q  <= sel_data;
            end
        end
    end

    assign RegWE = regwe_q;
    assign nD    = nd_q;
    assign D     = d_q;
    assign busyA = busy_q[nA];
    assign busyB = busy_q[nB];
    assign busyC = busy_q[nC];
    assign idle  = (busy_q == '0) && !regwe_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a round-robin/busy-set reference model predicts grants
// and write-backs; a separate monitor checks the register file write port.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NR   = 16;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          mark_valid = 1'b0;
    logic [AW-1:0] mark_addr = '0;
    logic          mark_ready;
    logic [AW-1:0] nA = '0, nB = '0, nC = '0;
    logic          busyA, busyB, busyC, idle, RegWE;
    logic [AW-1:0] nD;
    logic [DW-1:0] D;

    regfile_wb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wb ();

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .Reset(Reset), .wb(wb),
        .RegWE(RegWE), .nD(nD), .D(D),
        .mark_valid(mark_valid), .mark_addr(mark_addr), .mark_ready(mark_ready),
        .nA(nA), .nB(nB), .nC(nC),
        .busyA(busyA), .busyB(busyB), .busyC(busyC), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t exp_q[$];

    bit  m_busy[NR];
    int  m_ptr = 0;
    bit  m_out_v = 0;
    int  m_out_a = 0;
    bit  prev_rst = 0;
    bit  done = 0;

    bit            pv[NREQ];
    logic [AW-1:0] pa[NREQ];
    logic [DW-1:0] pd[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check combinational
    // outputs mid-cycle, then advance the reference model across the next edge.
    task automatic step(input bit rst, input bit mv, input logic [AW-1:0] ma,
                        input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_rdy;
        int g;
        bit acc;
        bit allz;
        @(posedge clk); #1;
        Reset = rst; mark_valid = mv; mark_addr = ma; nA = a; nB = b; nC = c;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = pv[i];
            wb.req_addr[i*AW +: AW] = pa[i];
            wb.req_data[i*DW +: DW] = pd[i];
        end
        wb.req_valid = v;
        @(negedge clk);
        g = -1;
        if (!rst)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && pv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        allz = 1;
        for (int r = 0; r < NR; r++) if (m_busy[r]) allz = 0;
        chk("req_ready", 32'(wb.req_ready), 32'(exp_rdy));
        chk("mark_ready", 32'(mark_ready), 32'(!rst && !m_busy[ma]));
        chk("busyA", 32'(busyA), 32'(m_busy[a]));
        chk("busyB", 32'(busyB), 32'(m_busy[b]));
        chk("busyC", 32'(busyC), 32'(m_busy[c]));
        chk("idle", 32'(idle), 32'(allz && !m_out_v));
        if (prev_rst) begin
            chk("nD_after_reset", 32'(nD), 32'd0);
            chk("D_after_reset", 32'(D), 32'd0);
        end
        if (rst) begin
            for (int r = 0; r < NR; r++) m_busy[r] = 0;
            m_ptr = 0;
            m_out_v = 0;
        end else begin
            acc = mv && !m_busy[ma];
            if (m_out_v) m_busy[m_out_a] = 0;
            if (acc) m_busy[ma] = 1;
            if (g >= 0) begin
                exp_q.push_back('{a: pa[g], d: pd[g]});
                m_ptr = (g + 1) % NREQ;
                m_out_v = 1;
                m_out_a = int'(pa[g]);
                pv[g] = 0;
            end else begin
                m_out_v = 0;
            end
        end
        prev_rst = rst;
    endtask

    task automatic idle_step();
        step(0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic refill_all();
        for (int i = 0; i < NREQ; i++)
            if (!pv[i]) begin
                pv[i] = 1;
                pa[i] = AW'($urandom_range(0, NR - 1));
                pd[i] = DW'($urandom);
            end
    endtask

    // Write-port monitor: each granted write must appear exactly one cycle later.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk); #2;
            if (done) break;
            chk("RegWE", 32'(RegWE), 32'(exp_q.size() != 0));
            if (RegWE === 1'b1 && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("nD", 32'(nD), 32'(w.a));
                chk("D", 32'(D), 32'(w.d));
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end
        wb.req_valid = '0; wb.req_addr = '0; wb.req_data = '0;

        // Reset, quiet, then reset with every requester valid.
        step(1, 0, 4'd0, 4'd0, 4'd1, 4'd2);
        idle_step();
        idle_step();
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1; pa[i] = AW'(i + 1); pd[i] = DW'(16'h1000 + i); end
        step(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        step(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        idle_step();
        idle_step();

        // Single requester 1.
        pv[1] = 1; pa[1] = 4'd5; pd[1] = 16'hBEEF;
        idle_step();
        idle_step();
        idle_step();

        // All three continuously valid after reset.
        step(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        for (int n = 0; n < 6; n++) begin refill_all(); idle_step(); end
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        idle_step();
        idle_step();

        // Mark r3, observe busy, then write it via requester 2.
        step(0, 1, 4'd3, 4'd3, 4'd0, 4'd0);
        step(0, 1, 4'd3, 4'd3, 4'd3, 4'd3);
        pv[2] = 1; pa[2] = 4'd3; pd[2] = 16'h0303;
        for (int n = 0; n < 4; n++) step(0, 0, 4'd0, 4'd3, 4'd0, 4'd0);

        // Mark r7 on the same edge that the output stage writes r7.
        pv[0] = 1; pa[0] = 4'd7; pd[0] = 16'h0707;
        step(0, 0, 4'd0, 4'd7, 4'd0, 4'd0);
        step(0, 1, 4'd7, 4'd7, 4'd0, 4'd0);
        step(0, 0, 4'd0, 4'd7, 4'd7, 4'd7);
        step(0, 0, 4'd0, 4'd7, 4'd0, 4'd0);

        // Reset while the output stage holds a write.
        pv[0] = 1; pa[0] = 4'd9; pd[0] = 16'h5A5A;
        step(0, 1, 4'd9, 4'd9, 4'd7, 4'd0);
        step(1, 0, 4'd0, 4'd9, 4'd7, 4'd0);
        step(0, 0, 4'd0, 4'd9, 4'd7, 4'd0);
        idle_step();

        // Randomized traffic with hazards concentrated on a few registers.
        for (int n = 0; n < 600; n++) begin
            bit rst;
            for (int i = 0; i < NREQ; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1;
                    pa[i] = AW'($urandom_range(0, 7));
                    pd[i] = DW'($urandom);
                end
            rst = ($urandom_range(0, 60) == 0);
            step(rst, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 15)));
        end
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        for (int n = 0; n < 4; n++) idle_step();

        @(posedge clk); #3;
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 16 x 16-bit register file. It shares the register file's single write port (`RegWE`/`nD`/`D`) among `NREQ` result producers (ALU, load unit, move/immediate path) with round-robin fairness and a valid/ready handshake. It also keeps a per-register busy scoreboard so that issue logic can stall reads of registers with outstanding writes. It sits between the execution units and the register file and drives the register file write port directly.

## Interface
- `NREQ`, 3, number of write-back requesters (2..4)
- `DW`, 16, data width
- `AW`, 4, register address width (16 registers)

- `clk`  input  1  clock; all state updates on the rising edge
- `Reset`  input  1  synchronous, active-high reset
- `req_valid`  input  NREQ  requester i holds a write
- `req_ready`  output  NREQ  grant to requester i; transfer when `req_valid[i] & req_ready[i]`
- `req_addr`  input  NREQ*AW  destination register; requester i at bits [i*AW +: AW]
- `req_data`  input  NREQ*DW  write data; requester i at bits [i*DW +: DW]
- `RegWE`  output  1  register file write enable (registered)
- `nD`  output  AW  register file write address (registered)
- `D`  output  DW  register file write data (registered)
- `mark_valid`  input  1  issue logic requests to mark `mark_addr` busy
- `mark_addr`  input  AW  register to mark busy
- `mark_ready`  output  1  `~busy[mark_addr]`; mark accepted when `mark_valid & mark_ready`
- `nA`, `nB`, `nC`  input  AW each  read-port addresses being issued
- `busyA`, `busyB`, `busyC`  output  1 each  `busy[nA]`, `busy[nB]`, `busy[nC]`, combinational
- `idle`  output  1  `busy == 0 && !RegWE`

## Operation
- Arbitration is combinational on `req_valid` and the round-robin pointer `ptr` (0..NREQ-1).
  - Search starts at requester `ptr` and proceeds upward with wrap-around. The first valid requester gets `req_ready`.
  - Exactly one `req_ready` bit is high at a time, and only if some `req_valid` is high.
- On a transfer from requester g:
  - `ptr <= (g+1) mod NREQ`.
  - `RegWE <= 1`, `nD <= req_addr[g]`, `D <= req_data[g]`.
- With no transfer: `RegWE <= 0`, `ptr` unchanged, and `nD`/`D` hold their last values.
- The write port accepts one write per cycle and never back-pressures.
- Requesters must hold `req_valid`/`req_addr`/`req_data` stable until granted. The block does not check this.
- Scoreboard `busy[15:0]`:
  - set: accepted mark sets `busy[mark_addr]`
  - clear: `RegWE` high at an edge clears `busy[nD]`. This is the same edge on which the register file commits the write.
  - The same register set and cleared at one edge: set wins (new outstanding write).
- Writes to non-busy registers are legal and pass through. Clearing an already-clear bit has no effect.
- `mark_ready` looks only at current `busy`. A same-cycle clear does not make it ready.

## Timing
- Reset (`Reset` high at an edge):
  - `RegWE=0`, `nD=0`, `D=0`, `busy=0`, `ptr=0`.
  - While `Reset` is high, `req_ready=0` and `mark_ready=0`, so no transfer or mark occurs.
- Reset mid-operation:
  - Pending requests are neither granted nor written.
  - An output write registered in the cycle before reset still reaches the register file on the reset edge. The register file's reset has priority there.
- Latency:
  - Grant and transfer in cycle N.
  - `RegWE`/`nD`/`D` valid in cycle N+1.
  - Register file updated at the end of N+1.
  - Busy bit clear visible in N+2, together with the new read data.
- Throughput: one write per cycle sustained. With all requesters valid, each is granted once per NREQ cycles.
- `busyA/B/C`, `mark_ready` and `req_ready` are combinational from registered state and inputs, with no registered delay.

## Test plan
- Reset, then no activity -> `RegWE=0`, `busy=0`, `idle=1`; Reset high with `req_valid=3'b111` -> `req_ready=0`, no write next cycle.
- Only requester 1 valid, addr 5, data 16'hBEEF -> `req_ready=3'b010` that cycle; next cycle `RegWE=1`, `nD=5`, `D=16'hBEEF`; cycle after, `RegWE=0`.
- All three valid continuously for 6 cycles after reset -> grant order 0,1,2,0,1,2; `RegWE` high for 6 consecutive cycles.
- Mark r3 (`mark_ready=1` seen), then `nA=3` -> `busyA=1`, `mark_ready=0` for r3; write r3 via requester 2 -> `busyA=1` through the `RegWE` cycle and 0 the cycle after.
- Mark r7 in the same cycle that the output stage writes r7 (r7 initially clear) -> `busy[7]=1` afterwards.
- Requester 0 valid, grant, then `Reset` asserted the cycle `RegWE=1` -> next cycle all outputs 0, `ptr=0`, `busy=0`.
